// File: rtl/cpu_dbg_dumper.sv
// Runs the CPU until halt or a cycle limit, then streams PC, registers and a
// data-memory window out as a byte stream over a valid/ready handshake.
module cpu_dbg_dumper #(
    parameter int DM_ADDR_BIT = 10,
    parameter int DM_BASE     = 0,
    parameter int DM_WORDS    = 16,
    parameter int DM_STEP     = 4,
    parameter int RUN_LIMIT   = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   cpu_en,
    input  logic                   cpu_halted,
    input  logic [31:0]            pc_dbg,
    output logic [4:0]             regfile_req_dbg,
    input  logic [31:0]            regfile_data_dbg,
    output logic [DM_ADDR_BIT-1:0] datamem_addr_dbg,
    input  logic [31:0]            datamem_data_dbg,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_HDR, S_SETUP, S_CAP, S_EMIT, S_DONE
    } state_e;

    localparam logic [8:0]  W_LAST = 9'(32 + DM_WORDS);
    localparam logic [31:0] LIMIT  = 32'(RUN_LIMIT);

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [8:0]             w_q, w_d;
    logic [1:0]             bcnt_q, bcnt_d;
    logic [31:0]            shift_q, shift_d;
    logic                   valid_q, valid_d;
    logic [4:0]             req_q, req_d;
    logic [DM_ADDR_BIT-1:0] addr_q, addr_d;
    logic                   xfer, lim, load_addr;
    logic [31:0]            cap_word;

    assign xfer = valid_q && out_ready;
    assign lim  = (cnt_q == LIMIT);

    always_comb begin
        if (w_q == 9'd0)
            cap_word = pc_dbg;
        else if (w_q <= 9'd32)
            cap_word = regfile_data_dbg;
        else
            cap_word = datamem_data_dbg;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        valid_d   = valid_q;
        req_d     = req_q;
        addr_d    = addr_q;
        load_addr = 1'b0;
        cpu_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    w_d     = '0;
                end
            end
            S_RUN: begin
                // Once the limit is reached the CPU stays off for the exit cycle
                cpu_en = !cpu_halted && !lim;
                if (cpu_en)
                    cnt_d = cnt_q + 32'd1;
                if (cpu_halted) begin
                    state_d = S_HDR;
                    shift_d = {8'hA5, 24'h0};
                    valid_d = 1'b1;
                end else if (lim) begin
                    state_d = S_HDR;
                    shift_d = {8'h5A, 24'h0};
                    valid_d = 1'b1;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    valid_d   = 1'b0;
                    state_d   = S_SETUP;
                    load_addr = 1'b1;
                end
            end
            S_SETUP: state_d = S_CAP;
            S_CAP: begin
                shift_d = cap_word;
                valid_d = 1'b1;
                bcnt_d  = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (xfer) begin
                    if (bcnt_q == 2'd3) begin
                        valid_d = 1'b0;
                        w_d     = w_q + 9'd1;
                        if (w_q == W_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_SETUP;
                            load_addr = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[23:0], 8'h00};
                        bcnt_d  = bcnt_q + 2'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Debug addresses are registered so they are stable from SETUP on
        if (load_addr) begin
            if (w_d >= 9'd1 && w_d <= 9'd32)
                req_d = 5'(w_d - 9'd1);
            if (w_d >= 9'd33)
                addr_d = DM_ADDR_BIT'(DM_BASE)
                       + DM_ADDR_BIT'(w_d - 9'd33) * DM_ADDR_BIT'(DM_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            req_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign regfile_req_dbg  = req_q;
    assign datamem_addr_dbg = addr_q;
    assign out_byte         = shift_q[31:24];
    assign out_valid        = valid_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu_dbg_dumper.sv
// Directed bench for cpu_dbg_dumper: normal dump, backpressure, restart,
// timeout and halt/limit coincidence on a second, short-limit instance.
module tb_cpu_dbg_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b;
    logic en_a, halted_a, valid_a, ready_a, busy_a, done_a;
    logic en_b, halted_b, valid_b, ready_b, busy_b, done_b;
    logic [31:0] pc_a, rdata_a, mdata_a, pc_b, rdata_b, mdata_b;
    logic [4:0] req_a, req_b;
    logic [9:0] addr_a, addr_b;
    logic [7:0] byte_a, byte_b;

    int tests = 0;
    int fails = 0;
    int halt_at_a = 10;
    int halt_at_b = 5;
    int en_cnt_a = 0;
    int en_cnt_b = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int stall_err = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    assign halted_a = (en_cnt_a >= halt_at_a);
    assign halted_b = (en_cnt_b >= halt_at_b);
    assign pc_a     = 32'h0000_0040;
    assign pc_b     = 32'h0000_0040;
    assign rdata_a  = 32'h100 + {27'b0, req_a};
    assign rdata_b  = 32'h100 + {27'b0, req_b};
    assign mdata_a  = {22'b0, addr_a} ^ 32'hFFFF_FFFF;
    assign mdata_b  = {22'b0, addr_b} ^ 32'hFFFF_FFFF;

    cpu_dbg_dumper u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .cpu_en(en_a), .cpu_halted(halted_a), .pc_dbg(pc_a),
        .regfile_req_dbg(req_a), .regfile_data_dbg(rdata_a),
        .datamem_addr_dbg(addr_a), .datamem_data_dbg(mdata_a),
        .out_byte(byte_a), .out_valid(valid_a), .out_ready(ready_a),
        .busy(busy_a), .done(done_a)
    );

    cpu_dbg_dumper #(.DM_WORDS(1), .RUN_LIMIT(5)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
        .cpu_en(en_b), .cpu_halted(halted_b), .pc_dbg(pc_b),
        .regfile_req_dbg(req_b), .regfile_data_dbg(rdata_b),
        .datamem_addr_dbg(addr_b), .datamem_data_dbg(mdata_b),
        .out_byte(byte_b), .out_valid(valid_b), .out_ready(ready_b),
        .busy(busy_b), .done(done_b)
    );

    // CPU models, consumers and stall monitor
    always @(posedge clk) begin
        if (start_a && !busy_a) en_cnt_a <= 0;
        else if (en_a) en_cnt_a <= en_cnt_a + 1;
        if (start_b && !busy_b) en_cnt_b <= 0;
        else if (en_b) en_cnt_b <= en_cnt_b + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (start_a && !busy_a) q_a.delete();
        else if (valid_a && ready_a) q_a.push_back(byte_a);
        if (start_b && !busy_b) q_b.delete();
        else if (valid_b && ready_b) q_b.push_back(byte_b);
        if (prev_stall && (!valid_a || byte_a != prev_byte))
            stall_err <= stall_err + 1;
        prev_stall <= valid_a && !ready_a;
        prev_byte  <= byte_a;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] hdr);
        int k, b;
        logic [31:0] wd;
        if (i == 0) return hdr;
        k = (i - 1) / 4;
        b = (i - 1) % 4;
        if (k == 0) wd = 32'h40;
        else if (k <= 32) wd = 32'h100 + k - 1;
        else wd = (((k - 33) * 4) & 32'h3FF) ^ 32'hFFFF_FFFF;
        return 8'(wd >> (8 * (3 - b)));
    endfunction

    task automatic check_frame(input bit b, input logic [7:0] hdr,
                               input int dmw, input string tag);
        logic [7:0] q[$];
        int len;
        if (b) q = q_b;
        else q = q_a;
        len = 1 + 4 * (33 + dmw);
        chk({tag, " length"}, q.size(), len);
        for (int i = 0; i < len && i < q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), {24'b0, q[i]},
                {24'b0, exp_byte(i, hdr)});
    endtask

    task automatic run_a(input bit bp, input int budget);
        int n = 0;
        int d0 = done_cnt_a;
        bit poked = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        while (!done_a && n < budget) begin
            if (bp) ready_a = (n % 4 == 0) || (n % 4 == 3);
            if (bp && !poked && valid_a && q_a.size() >= 6) begin
                start_a = 1'b1;
                poked   = 1;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        chk("run_a timeout", {31'b0, n < budget}, 1);
        repeat (30) @(negedge clk);
        chk("done_a pulses", done_cnt_a - d0, 1);
        chk("busy_a idle", {31'b0, busy_a}, 0);
    endtask

    task automatic run_b(input int budget);
        int n = 0;
        int d0 = done_cnt_b;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        while (!done_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_b timeout", {31'b0, n < budget}, 1);
        repeat (10) @(negedge clk);
        chk("done_b pulses", done_cnt_b - d0, 1);
        chk("busy_b idle", {31'b0, busy_b}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst valid", {31'b0, valid_a}, 0);
        chk("rst busy", {31'b0, busy_a}, 0);
        chk("rst done", {31'b0, done_a}, 0);
        chk("rst en", {31'b0, en_a}, 0);
        chk("rst byte", {24'b0, byte_a}, 0);
        chk("rst req", {27'b0, req_a}, 0);
        chk("rst addr", {22'b0, addr_a}, 0);
        chk("rst busy_b", {31'b0, busy_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        halt_at_a = 10;
        run_a(0, 2000);
        chk("basic en cycles", en_cnt_a, 10);
        check_frame(0, 8'hA5, 16, "basic");

        run_a(1, 4000);
        chk("bp en cycles", en_cnt_a, 10);
        chk("bp stall stable", stall_err, 0);
        check_frame(0, 8'hA5, 16, "bp");

        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 0;
        while (q_a.size() < 50 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid timeout", {31'b0, n < 2000}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid valid", {31'b0, valid_a}, 0);
        chk("mid busy", {31'b0, busy_a}, 0);
        chk("mid en", {31'b0, en_a}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid stays idle", {31'b0, busy_a}, 0);
        run_a(0, 2000);
        check_frame(0, 8'hA5, 16, "restart");

        halt_at_b = 1 << 30;
        run_b(1000);
        chk("timeout en cycles", en_cnt_b, 5);
        check_frame(1, 8'h5A, 1, "timeout");

        halt_at_b = 5;
        run_b(1000);
        chk("coincide en cycles", en_cnt_b, 5);
        check_frame(1, 8'hA5, 1, "coincide");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
